data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Data memory of the single-cycle RISC-V processor.
- Serves loads and stores issued by the datapath.
- Byte-addressable little-endian storage with 32-bit word accesses at any byte address.
- Read is combinational so a load completes in the same cycle. Write commits on the rising clock edge. A synchronous clear zeroes the whole array.

Parameters:
- DATA_WIDTH, 32, width of data_in/data_out in bits; must be a multiple of 8 (bytes per word N = DATA_WIDTH/8).
- ADDRESS_WIDTH, 32, width of addr in bits.
- DEPTH_BYTES, 256, number of byte locations; power of two, at least N.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- clr  input  1  synchronous active-high reset; clears entire memory.
- write_en  input  1  store enable; when high, data_in is written at addr on the rising edge.
- addr  input  ADDRESS_WIDTH  byte address of the access.
- data_in  input  DATA_WIDTH  store data.
- data_out  output  DATA_WIDTH  load data, combinational from addr and current contents.

Behaviour:
- Storage: DEPTH_BYTES registers of 8 bits each. Effective byte index = addr mod DEPTH_BYTES; upper address bits are ignored.
- Word layout: little-endian. Byte k of a word (bits 8k+7:8k), k = 0..N-1, lives at index (addr + k) mod DEPTH_BYTES.
- Unaligned accesses are legal, with no trap or flag.
- Wrap-around: a word spanning the top of the array continues at index 0.
- Read:
  - data_out = concatenation of the N bytes at addr..addr+N-1, byte addr in the LSBs.
  - Purely combinational: 0-cycle latency, no clock involved.
  - Follows addr changes and post-edge content changes within the same cycle.
- Write:
  - On rising clk with write_en=1 and clr=0, all N bytes at addr..addr+N-1 take data_in simultaneously.
  - The new value is visible on data_out immediately after that edge.
  - write_en=0: contents unchanged.
- Reset:
  - On rising clk with clr=1, every byte becomes 0 in that single edge.
  - clr has priority over write_en: a simultaneous write is discarded.
  - After reset, data_out = 0 for every addr.
- Power-up: contents undefined until the first clr edge. The bench always applies clr first.
- Overlapping writes: a later write overwrites only the bytes it covers. Bytes outside its range are untouched.
- Read-during-write:
  - Same-cycle read before the edge returns the old data.
  - After the edge, it returns the new data.
- No other outputs, handshakes or state machines.

Test Plan:
- Reset and basic store/load:
  - Hold clr=1 for one edge, then clr=0. data_out=0 at addr 0, 20, 25 and 255.
  - Write 10 @20, 22 @25, 87 @0 on successive edges with write_en=1.
  - Read addr 20 -> 10, addr 0 -> 87, addr 25 -> 22.
  - write_en=0 cycles leave the contents unchanged.
- Unaligned overlap:
  - After reset, write 0x11223344 @0, then read addr 1 -> 0x00112233 and addr 2 -> 0x00001122.
  - Write 0xAABBCCDD @2, then read addr 0 -> 0xCCDD3344 and addr 4 -> 0x0000AABB.
- Wrap-around:
  - Write 0xAABBCCDD @254.
  - Bytes 254=DD, 255=CC, 0=BB, 1=AA.
  - Read addr 254 -> 0xAABBCCDD, addr 0 -> 0x0000AABB.
  - Read addr 0x1FE (upper bits ignored) -> 0xAABBCCDD.
- Reset priority:
  - With earlier data present, assert clr=1 together with write_en=1, addr=8, data_in=0x55.
  - After the edge, all reads = 0, including addr 8.
- Read-during-write:
  - Address 12 holds 0x1234. Drive write_en=1, addr=12, data_in=0xBEEF.
  - data_out = 0x1234 before the edge and 0xBEEF after it.
- Random regression:
  - 1000 random writes/reads, plus occasional clr, compared against a byte-array reference model using the mod-DEPTH_BYTES, little-endian and clr-priority rules.

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the single-cycle RISC-V core.
// Word loads are combinational; word stores and the whole-array clear commit on the rising edge.
module data_memory #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_BYTES   = 256
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     write_en,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out
);

  localparam int N     = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0] mem [DEPTH_BYTES];

  // Only the low address bits select a byte; the rest are ignored by design.
  logic unused_addr;
  assign unused_addr = ^addr;

  // Index of byte k of the word at a; the IDX_W-bit sum wraps past the top of the array.
  function automatic logic [IDX_W-1:0] byte_index(input logic [ADDRESS_WIDTH-1:0] a,
                                                  input int k);
    return a[IDX_W-1:0] + IDX_W'(k);
  endfunction

  always_comb begin
    data_out = '0;
    for (int k = 0; k < N; k++) begin
      data_out[8*k +: 8] = mem[byte_index(addr, k)];
    end
  end

  // NOTE: the array is cleared in one edge by clr, so it is built from flops and
  // cannot be mapped onto a RAM macro; clr is checked first so it wins over a store.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      for (int k = 0; k < N; k++) begin
        mem[byte_index(addr, k)] <= data_in[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected load values, a
// negedge monitor pops and compares them against data_out.
module tb_data_memory;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          write_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;

  data_memory #(
    .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(AW),
    .DEPTH_BYTES(DEPTH)
  ) dut (
    .clk(clk),
    .clr(clr),
    .write_en(write_en),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain byte array indexed modulo the depth.
  logic [7:0] ref_mem [DEPTH];

  logic [DW-1:0] exp_q  [$];
  logic [AW-1:0] addr_q [$];
  string         name_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    longint unsigned base;
    w = '0;
    base = longint'(a) % DEPTH;
    for (int k = 0; k < NB; k++) begin
      w[8*k +: 8] = ref_mem[int'((base + longint'(k)) % DEPTH)];
    end
    return w;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    longint unsigned base;
    base = longint'(a) % DEPTH;
    for (int k = 0; k < NB; k++) begin
      ref_mem[int'((base + longint'(k)) % DEPTH)] = d[8*k +: 8];
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endfunction

  task automatic check(input string name, input logic [AW-1:0] a,
                       input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s addr=0x%08h got=0x%08h expected=0x%08h", name, a, actual, expected);
  endtask

  // Monitor: data_out is valid combinationally, so sample it mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [DW-1:0] e;
      logic [AW-1:0] a;
      string nm;
      e  = exp_q.pop_front();
      a  = addr_q.pop_front();
      nm = name_q.pop_front();
      check(nm, a, data_out, e);
    end
  end

  task automatic push_exp(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    exp_q.push_back(e);
    addr_q.push_back(a);
    name_q.push_back(name);
  endtask

  // Load with a fixed expected value.
  task automatic read_const(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    write_en = 1'b0;
    clr      = 1'b0;
    addr     = a;
    push_exp(name, a, e);
    @(posedge clk); #1;
  endtask

  // Load checked against the reference model.
  task automatic read_model(input string name, input logic [AW-1:0] a);
    read_const(name, a, model_read(a));
  endtask

  // Store; before the edge the old contents must still be visible at addr.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    clr      = 1'b0;
    write_en = 1'b1;
    addr     = a;
    data_in  = d;
    push_exp("read_before_write", a, model_read(a));
    @(posedge clk);
    model_write(a, d);
    #1;
    write_en = 1'b0;
  endtask

  task automatic do_clr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    clr      = 1'b1;
    write_en = we;
    addr     = a;
    data_in  = d;
    @(posedge clk);
    model_clear();
    #1;
    clr      = 1'b0;
    write_en = 1'b0;
  endtask

  initial begin
    int budget;
    @(posedge clk); #1;

    // Reset and basic store/load
    do_clr(1'b0, '0, '0);
    read_const("reset_zero_0",   32'd0,   32'd0);
    read_const("reset_zero_20",  32'd20,  32'd0);
    read_const("reset_zero_25",  32'd25,  32'd0);
    read_const("reset_zero_255", 32'd255, 32'd0);
    do_write(32'd20, 32'd10);
    do_write(32'd25, 32'd22);
    do_write(32'd0,  32'd87);
    read_const("basic_20", 32'd20, 32'd10);
    read_const("basic_0",  32'd0,  32'd87);
    read_const("basic_25", 32'd25, 32'd22);
    repeat (3) begin
      addr = 32'd20; data_in = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end
    read_const("idle_20", 32'd20, 32'd10);
    read_const("idle_25", 32'd25, 32'd22);

    // Unaligned overlap
    do_clr(1'b0, '0, '0);
    do_write(32'd0, 32'h1122_3344);
    read_const("unaligned_1", 32'd1, 32'h0011_2233);
    read_const("unaligned_2", 32'd2, 32'h0000_1122);
    do_write(32'd2, 32'hAABB_CCDD);
    read_const("overlap_0", 32'd0, 32'hCCDD_3344);
    read_const("overlap_4", 32'd4, 32'h0000_AABB);

    // Wrap-around past the top of the array
    do_clr(1'b0, '0, '0);
    do_write(32'd254, 32'hAABB_CCDD);
    read_const("wrap_254",   32'd254,   32'hAABB_CCDD);
    read_const("wrap_255",   32'd255,   32'h00AA_BBCC);
    read_const("wrap_0",     32'd0,     32'h0000_AABB);
    read_const("wrap_1fe",   32'h1FE,   32'hAABB_CCDD);
    read_const("wrap_high",  32'hFFFF_FF00, 32'h0000_AABB);

    // clr wins over a simultaneous store
    do_write(32'd8, 32'h0102_0304);
    do_clr(1'b1, 32'd8, 32'h0000_0055);
    read_const("clr_prio_8",   32'd8,   32'd0);
    read_const("clr_prio_0",   32'd0,   32'd0);
    read_const("clr_prio_254", 32'd254, 32'd0);

    // Read-during-write
    do_write(32'd12, 32'h0000_1234);
    clr = 1'b0; write_en = 1'b1; addr = 32'd12; data_in = 32'h0000_BEEF;
    push_exp("rdw_old", 32'd12, 32'h0000_1234);
    @(posedge clk);
    model_write(32'd12, 32'h0000_BEEF);
    #1;
    write_en = 1'b0;
    push_exp("rdw_new_same_cycle", 32'd12, 32'h0000_BEEF);
    @(posedge clk); #1;
    read_const("rdw_new", 32'd12, 32'h0000_BEEF);

    // Random regression against the byte-array model
    for (int i = 0; i < 1000; i++) begin
      int unsigned r;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      r  = $urandom_range(0, 99);
      ra = (r[0]) ? AW'($urandom) : AW'($urandom_range(0, DEPTH - 1));
      rd = DW'($urandom);
      if (r < 2)       do_clr(1'($urandom_range(0, 1)), ra, rd);
      else if (r < 50) do_write(ra, rd);
      else             read_model("random_read", ra);
    end
    for (int i = 0; i < DEPTH; i += 4) read_model("final_sweep", AW'(i + (i % 3)));

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    while (exp_q.size() != 0) begin
      logic [DW-1:0] e;
      logic [AW-1:0] a;
      string nm;
      e  = exp_q.pop_front();
      a  = addr_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      $display("FAIL %s addr=0x%08h never sampled, expected=0x%08h", nm, a, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
